ri_weight_streamer: RTL and testbench
=====================================

Name: ri_weight_streamer

Overview:
- Reader/sequencer for the recurrent-weight ROM `ri_buffer`. It drives the ROM `addr` and captures each `UNITS_NUM*D_WL` row from `w_o`.
- It streams a contiguous run of rows to the LSTM gate MAC array over a valid/ready interface, with one row per beat at full throughput.
- It sits between `ri_buffer` and the per-timestep recurrent MAC stage. The LSTM controller starts it once per gate pass.

Parameters:
- D_WL, 24, bit width of one weight word.
- UNITS_NUM, 5, weight words per ROM row.
- DEPTH, 180, number of ROM rows; valid addresses are 0..DEPTH-1.
- ADDR_W, 8, ROM address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, pulse that launches a run; accepted only when busy=0.
- base, in, ADDR_W, first row of the run; sampled when start is accepted.
- len, in, ADDR_W+1, number of rows in the run; sampled when start is accepted.
- abort, in, 1, synchronous cancel of the current run.
- rom_addr, out, ADDR_W, address to `ri_buffer.addr`.
- rom_data, in, UNITS_NUM*D_WL, data from `ri_buffer.w_o` (combinational ROM).
- w_valid, out, 1, output beat valid.
- w_ready, in, 1, downstream accepts the beat.
- w_data, out, UNITS_NUM*D_WL, weight row; word k occupies bits [k*D_WL +: D_WL].
- w_idx, out, ADDR_W, ROM row index carried by this beat.
- w_last, out, 1, marks the final beat of the run.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; rom_addr=0; internal remaining-count register=0.
- FSM states are IDLE, FETCH and DRAIN.
- IDLE:
  - On start with len!=0: latch base into rom_addr, set remaining=len, set busy=1, go to FETCH.
  - On start with len==0: no run; emit done pulse the next cycle; busy stays 0.
  - start while busy=1 is ignored.
- FETCH:
  - Load condition is advance = !w_valid || w_ready, and remaining!=0.
  - On a load: output register takes w_data<=rom_data, w_idx<=rom_addr, w_last<=(remaining==1), w_valid<=1.
  - Also on a load: rom_addr increments and wraps DEPTH-1 -> 0; remaining decrements.
  - When remaining reaches 0 after the load, go to DRAIN.
- DRAIN:
  - When w_valid && w_ready: clear w_valid and w_last, pulse done, clear busy, go to IDLE.
- Latency: the first beat is valid on the cycle after start acceptance.
- Throughput: with w_ready held at 1, a run of len rows produces len beats on consecutive cycles. Done is asserted the cycle after the last handshake.
- Backpressure:
  - While w_valid && !w_ready, w_data, w_idx and w_last hold stable and rom_addr does not change.
  - w_valid never drops without a handshake, except on abort or reset.
- Wrap-around: base+len > DEPTH wraps to row 0. A run with len > DEPTH repeats rows modulo DEPTH.
- Out-of-range base: base >= DEPTH is clamped to 0 at start acceptance.
- Abort:
  - In any state, abort has priority over start and over the handshake.
  - Next cycle: w_valid=0, w_last=0, busy=0, state IDLE, no done pulse.
  - A beat presented together with abort is treated as not transferred.
- Reset asserted mid-run: immediate return to the reset values. A subsequent start behaves as if from power-up.
- w_ready asserted while w_valid=0 has no effect.

Decomposition:
- Shared package: D_WL, UNITS_NUM, DEPTH and ADDR_W constants, plus the FSM state encoding. The same constants are used by `ri_buffer` and the MAC stage.
- Sub-module: `ri_out_reg` is the natural one. It is the valid/ready output register holding data, idx and last, with load and clear controls.
- The FSM and address/count logic stay in the top-level module.

Test Plan:
- Full run, no stall: base=0, len=180, w_ready=1.
  - Expect 180 beats in cycles 1..180 after start.
  - Beat 0 data = 'h0001ac000e83001948ffe36bfff8d5, w_idx=0.
  - Beat 179 has w_idx=179, data = 'h00002c0000a2fff93200023b000a11, w_last=1.
  - done pulses at cycle 181.
- Wrap: base=178, len=4.
  - Expect w_idx sequence 178, 179, 0, 1, with w_last on idx 1.
  - The idx 0 beat carries row 0's data.
- Backpressure: base=5, len=3; w_ready low for 3 cycles while beat idx 5 is valid.
  - Expect data 'h0009ddfffc34fffa3dfffe79ffe33a held constant and rom_addr=6 held.
  - After release: idx 6 and 7 on consecutive cycles, then done.
- Abort mid-run: base=10, len=20; assert abort on the cycle beat idx 14 is valid.
  - Expect w_valid=0 and busy=0 next cycle, no done pulse.
  - A new start with base=0, len=1 then yields a single beat idx 0 with w_last=1.
- Edge cases:
  - len=0 gives a done pulse with no beats.
  - start during busy is ignored; beat count unchanged.
  - Async rst_n asserted mid-run clears all outputs within the same cycle.

Source files
------------

// File: rtl/ri_weight_streamer_pkg.sv
// Shared constants and FSM encoding for the recurrent-weight ROM streamer.
// The ROM and the MAC stage use the same geometry constants.
package ri_weight_streamer_pkg;

    localparam int unsigned D_WL      = 24;
    localparam int unsigned UNITS_NUM = 5;
    localparam int unsigned DEPTH     = 180;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned ROW_W     = UNITS_NUM * D_WL;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } ri_state_e;

endpackage

// File: rtl/ri_out_reg.sv
// Valid/ready output register holding one weight row, its index and the last flag.
// Clear has priority over load; data and index are kept on clear.
module ri_out_reg #(
    parameter int unsigned DataW = 120,
    parameter int unsigned IdxW  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [DataW-1:0] data_i,
    input  logic [IdxW-1:0]  idx_i,
    input  logic             last_i,
    output logic             valid_o,
    output logic [DataW-1:0] data_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             last_o
);

    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (clear_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            idx_d   = idx_i;
            last_d  = last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;

endmodule

// File: rtl/ri_weight_streamer.sv
// Sequences reads of the recurrent-weight ROM and streams a contiguous run of rows
// to the gate MAC array, one row per beat over valid/ready.
module ri_weight_streamer
    import ri_weight_streamer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base,
    input  logic [ADDR_W:0]    len,
    input  logic               abort,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [ROW_W-1:0]   rom_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [ROW_W-1:0]   w_data,
    output logic [ADDR_W-1:0]  w_idx,
    output logic               w_last,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   RemOne   = (ADDR_W + 1)'(1);

    ri_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load, clear, advance;

    assign advance = !w_valid || w_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;
        clear       = 1'b0;
        // Abort beats both start and handshake; a beat shown with abort is dropped.
        if (abort) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len != '0) begin
                            addr_d      = ({1'b0, base} >= DepthExt) ? '0 : base;
                            remaining_d = len;
                            busy_d      = 1'b1;
                            state_d     = StFetch;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (advance && (remaining_q != '0)) begin
                        load        = 1'b1;
                        addr_d      = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
                        remaining_d = remaining_q - RemOne;
                        if (remaining_q == RemOne) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_valid && w_ready) begin
                        clear   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    ri_out_reg #(
        .DataW (ROW_W),
        .IdxW  (ADDR_W)
    ) u_out_reg (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (load),
        .clear_i (clear),
        .data_i  (rom_data),
        .idx_i   (addr_q),
        .last_i  (remaining_q == RemOne),
        .valid_o (w_valid),
        .data_o  (w_data),
        .idx_o   (w_idx),
        .last_o  (w_last)
    );

    assign rom_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ri_weight_streamer.sv
// Self-checking bench: a queue-of-beats reference model compared every cycle,
// plus directed runs with hand-computed expectations and randomized runs.
module tb_ri_weight_streamer;
    import ri_weight_streamer_pkg::*;

    localparam logic [ROW_W-1:0] Row0   = 120'h0001ac000e83001948ffe36bfff8d5;
    localparam logic [ROW_W-1:0] Row5   = 120'h0009ddfffc34fffa3dfffe79ffe33a;
    localparam logic [ROW_W-1:0] Row179 = 120'h00002c0000a2fff93200023b000a11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROW_W-1:0]  rom_data;
    logic              w_valid;
    logic              w_ready;
    logic [ROW_W-1:0]  w_data;
    logic [ADDR_W-1:0] w_idx;
    logic              w_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    ri_weight_streamer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .len      (len),
        .abort    (abort),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_idx    (w_idx),
        .w_last   (w_last),
        .busy     (busy),
        .done     (done)
    );

    // ROM contents: three pinned rows, the rest a deterministic hash of the address.
    function automatic logic [ROW_W-1:0] rom_row(input logic [ADDR_W-1:0] a);
        logic [ROW_W-1:0] r;
        int unsigned      v;
        r = '0;
        if (a == 8'd0) r = Row0;
        else if (a == 8'd5) r = Row5;
        else if (a == 8'd179) r = Row179;
        else begin
            for (int k = 0; k < int'(UNITS_NUM); k++) begin
                v = (int'(a) * 40503 + k * 7919) ^ (int'(a) << (k + 3));
                r[k*D_WL +: D_WL] = v[D_WL-1:0];
            end
        end
        return r;
    endfunction

    assign rom_data = rom_row(rom_addr);

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [ROW_W-1:0]  data;
        logic              last;
    } beat_t;

    beat_t q[$];
    bit    m_busy, m_valid, m_warm, m_done;
    int    n_checks, n_fail;

    task automatic chk(input string name, input logic [ROW_W-1:0] act,
                       input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy  = 0;
        m_valid = 0;
        m_warm  = 0;
        m_done  = 0;
    endtask

    // One clock edge of the stream: the run becomes visible one edge after acceptance,
    // every accepted beat exposes the next row, done follows the final acceptance.
    task automatic model_step();
        beat_t bt;
        int    bc;
        m_done = 0;
        if (abort) begin
            q.delete();
            m_busy  = 0;
            m_valid = 0;
            m_warm  = 0;
        end else if (m_busy) begin
            if (m_warm) begin
                m_warm  = 0;
                m_valid = 1;
            end else if (m_valid && w_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_valid = 0;
                    m_busy  = 0;
                    m_done  = 1;
                end
            end
        end else if (start) begin
            if (len == 0) begin
                m_done = 1;
            end else begin
                bc = (int'(base) >= int'(DEPTH)) ? 0 : int'(base);
                for (int i = 0; i < int'(len); i++) begin
                    bt.idx  = ADDR_W'((bc + i) % int'(DEPTH));
                    bt.data = rom_row(bt.idx);
                    bt.last = (i == int'(len) - 1);
                    q.push_back(bt);
                end
                m_busy = 1;
                m_warm = 1;
            end
        end
    endtask

    task automatic compare();
        chk("w_valid", ROW_W'(w_valid), ROW_W'(m_valid));
        chk("busy", ROW_W'(busy), ROW_W'(m_busy));
        chk("done", ROW_W'(done), ROW_W'(m_done));
        if (m_valid && q.size() > 0) begin
            chk("w_idx", ROW_W'(w_idx), ROW_W'(q[0].idx));
            chk("w_data", w_data, q[0].data);
            chk("w_last", ROW_W'(w_last), ROW_W'(q[0].last));
            chk("rom_addr", ROW_W'(rom_addr), ROW_W'((int'(q[0].idx) + 1) % int'(DEPTH)));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic start_run(input int b, input int l);
        base  = ADDR_W'(b);
        len   = (ADDR_W + 1)'(l);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_w_valid"}, ROW_W'(w_valid), '0);
        chk({tag, "_busy"}, ROW_W'(busy), '0);
        chk({tag, "_done"}, ROW_W'(done), '0);
        chk({tag, "_rom_addr"}, ROW_W'(rom_addr), '0);
        chk({tag, "_w_data"}, w_data, '0);
        chk({tag, "_w_idx"}, ROW_W'(w_idx), '0);
        chk({tag, "_w_last"}, ROW_W'(w_last), '0);
    endtask

    // Random backpressure, rare aborts and ignored starts until the model goes idle.
    task automatic run_random(input int ready_pct, input int abort_pct);
        for (int i = 0; i < 3000 && m_busy; i++) begin
            w_ready = ($urandom_range(0, 99) < ready_pct);
            abort   = ($urandom_range(0, 99) < abort_pct);
            if ($urandom_range(0, 9) == 0) begin
                start = 1'b1;
                base  = ADDR_W'($urandom_range(0, 255));
                len   = (ADDR_W + 1)'($urandom_range(0, 30));
            end
            cycle();
            abort = 1'b0;
            start = 1'b0;
        end
        chk("run_idle_busy", ROW_W'(busy), '0);
    endtask

    int wrap_idx[4] = '{178, 179, 0, 1};
    int beats;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        abort   = 1'b0;
        w_ready = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Full run without stalls.
        w_ready = 1'b1;
        start_run(0, 180);
        for (int k = 1; k <= 181; k++) begin
            cycle();
            if (k == 1) begin
                chk("full_first_valid", ROW_W'(w_valid), 1);
                chk("full_first_data", w_data, Row0);
                chk("full_first_idx", ROW_W'(w_idx), 0);
            end
            if (k == 180) begin
                chk("full_last_idx", ROW_W'(w_idx), 179);
                chk("full_last_data", w_data, Row179);
                chk("full_last_flag", ROW_W'(w_last), 1);
            end
            if (k == 181) chk("full_done", ROW_W'(done), 1);
        end

        // Wrap-around past DEPTH-1.
        start_run(178, 4);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("wrap_idx", ROW_W'(w_idx), ROW_W'(wrap_idx[k-1]));
            if (k == 3) chk("wrap_row0_data", w_data, Row0);
            if (k == 4) chk("wrap_last", ROW_W'(w_last), 1);
        end
        cycle();
        chk("wrap_done", ROW_W'(done), 1);

        // Backpressure on the first beat.
        start_run(5, 3);
        cycle();
        chk("bp_first_idx", ROW_W'(w_idx), 5);
        w_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold_data", w_data, Row5);
            chk("bp_hold_addr", ROW_W'(rom_addr), 6);
            chk("bp_hold_valid", ROW_W'(w_valid), 1);
        end
        w_ready = 1'b1;
        cycle();
        chk("bp_idx6", ROW_W'(w_idx), 6);
        cycle();
        chk("bp_idx7", ROW_W'(w_idx), 7);
        chk("bp_idx7_last", ROW_W'(w_last), 1);
        cycle();
        chk("bp_done", ROW_W'(done), 1);

        // Abort while beat 14 is presented, then a one-row run.
        start_run(10, 20);
        for (int k = 1; k <= 5; k++) cycle();
        chk("abort_at_idx", ROW_W'(w_idx), 14);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_valid", ROW_W'(w_valid), 0);
        chk("abort_busy", ROW_W'(busy), 0);
        chk("abort_no_done", ROW_W'(done), 0);
        cycle();
        chk("abort_no_done_late", ROW_W'(done), 0);
        start_run(0, 1);
        cycle();
        chk("post_abort_idx", ROW_W'(w_idx), 0);
        chk("post_abort_last", ROW_W'(w_last), 1);
        cycle();
        chk("post_abort_done", ROW_W'(done), 1);

        // Zero-length run.
        start_run(7, 0);
        chk("len0_done", ROW_W'(done), 1);
        chk("len0_busy", ROW_W'(busy), 0);
        chk("len0_valid", ROW_W'(w_valid), 0);
        cycle();
        chk("len0_done_clear", ROW_W'(done), 0);

        // Out-of-range base clamps to row 0.
        start_run(200, 2);
        cycle();
        chk("clamp_idx", ROW_W'(w_idx), 0);
        cycle();
        cycle();

        // Start while busy is ignored.
        start_run(20, 5);
        beats = 0;
        for (int i = 0; i < 60 && m_busy; i++) begin
            w_ready = 1'($urandom_range(0, 1));
            if (i == 2) begin
                start = 1'b1;
                base  = 8'd100;
                len   = 9'd50;
            end
            if (w_valid && w_ready) beats++;
            cycle();
            start = 1'b0;
        end
        chk("busy_start_beats", ROW_W'(beats), 5);
        cycle();

        // Randomized runs, including len > DEPTH.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) start_run($urandom_range(0, 255), $urandom_range(181, 220));
            else start_run($urandom_range(0, 255), $urandom_range(0, 12));
            run_random(70, 2);
            w_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        // Asynchronous reset mid-run.
        w_ready = 1'b1;
        start_run(50, 10);
        cycle();
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        start_run(3, 2);
        cycle();
        chk("after_rst_idx", ROW_W'(w_idx), 3);
        run_random(100, 0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
